// File: rtl/eia608_call_scheduler.sv
// Round-robin scheduler sharing one eia608_from_utf8 kernel between two caption requesters, one call in flight.
// Optional hung-kernel abort (timer + FLUSH) is built when EIA608_SCHED_TIMEOUT_EN is defined.
module eia608_call_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMR_W          = 13
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [63:0] req0_s,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [63:0] req1_s,
    output logic        req1_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic        k_start,
    input  logic        k_busy,
    output logic [63:0] k_s,
    input  logic        k_done,
    output logic        k_stall,
    input  logic [31:0] k_returndata,
    output logic        k_reset,
    output logic        sched_idle
);

    if ((64'd1 << TMR_W) <= 64'(TIMEOUT_CYCLES)) begin : g_tmr_w_check
        $error("TMR_W too narrow to hold TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
`ifdef EIA608_SCHED_TIMEOUT_EN
        , S_FLUSH
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic [63:0] s_q, s_d;
    logic [31:0] data_q, data_d;
    logic        gnt0, gnt1;
`ifdef EIA608_SCHED_TIMEOUT_EN
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;
    logic             flush_q, flush_d;
    logic             tmo;
`endif

    // Grant depends only on registered state and requester valids.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        s_d     = s_q;
        data_d  = data_q;
`ifdef EIA608_SCHED_TIMEOUT_EN
        tmr_d   = tmr_q;
        err_d   = err_q;
        flush_d = flush_q;
        tmo     = (tmr_q == TMR_W'(TIMEOUT_CYCLES));
`endif
        case (state_q)
            S_IDLE: begin
`ifdef EIA608_SCHED_TIMEOUT_EN
                tmr_d   = '0;
                flush_d = 1'b0;
`endif
                if (gnt0 || gnt1) begin
                    s_d     = gnt1 ? req1_s : req0_s;
                    id_d    = gnt1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef EIA608_SCHED_TIMEOUT_EN
                tmr_d = tmr_q + 1'b1;
`endif
                if (!k_busy) begin
                    state_d = S_WAIT;
                end
`ifdef EIA608_SCHED_TIMEOUT_EN
                else if (tmo) begin
                    state_d = S_FLUSH;
                end
`endif
            end
            S_WAIT: begin
`ifdef EIA608_SCHED_TIMEOUT_EN
                tmr_d = tmr_q + 1'b1;
`endif
                // A done in the timeout cycle still wins.
                if (k_done) begin
                    data_d  = k_returndata;
                    state_d = S_RESP;
`ifdef EIA608_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
`ifdef EIA608_SCHED_TIMEOUT_EN
                else if (tmo) begin
                    state_d = S_FLUSH;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    last_d  = id_q;
                    state_d = S_IDLE;
                end
            end
`ifdef EIA608_SCHED_TIMEOUT_EN
            S_FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    data_d  = 32'hFFFF_FFFF;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            s_q     <= '0;
            data_q  <= '0;
`ifdef EIA608_SCHED_TIMEOUT_EN
            tmr_q   <= '0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            s_q     <= s_d;
            data_q  <= data_d;
`ifdef EIA608_SCHED_TIMEOUT_EN
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            flush_q <= flush_d;
`endif
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign sched_idle = (state_q == S_IDLE);
    assign k_start    = (state_q == S_ISSUE);
    assign k_stall    = (state_q != S_WAIT);
    assign k_s        = s_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_data   = data_q;
    assign rsp_id     = id_q;
`ifdef EIA608_SCHED_TIMEOUT_EN
    assign k_reset    = (state_q == S_FLUSH);
    assign rsp_err    = err_q;
`else
    assign k_reset    = 1'b0;
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_eia608_call_scheduler.sv
// Testbench for eia608_call_scheduler with a transaction-level model of requesters, kernel and consumer.
module tb_eia608_call_scheduler;
    localparam int TMO = 16;
    typedef enum int {P_IDLE, P_ISSUE, P_RUN, P_FLUSH, P_RESP} phase_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [63:0] req0_s = '0, req1_s = '0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_id, rsp_err;
    logic        k_start;
    logic        k_busy = 1'b0;
    logic [63:0] k_s;
    logic        k_done = 1'b0;
    logic        k_stall;
    logic [31:0] k_returndata = '0;
    logic        k_reset, sched_idle;

    eia608_call_scheduler #(.TIMEOUT_CYCLES(TMO), .TMR_W(5)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_s(req0_s), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_s(req1_s), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .k_start(k_start), .k_busy(k_busy), .k_s(k_s), .k_done(k_done),
        .k_stall(k_stall), .k_returndata(k_returndata), .k_reset(k_reset),
        .sched_idle(sched_idle)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Directed stimulus values, used when rnd is clear.
    bit          rnd = 1'b0;
    bit          d_req0_valid = 1'b0, d_req1_valid = 1'b0, d_busy = 1'b0, d_rsp_ready = 1'b1, d_spur = 1'b0;
    logic [63:0] d_req0_s = '0, d_req1_s = '0;
    int          lat_set = 1;
    logic [31:0] kdata_set = '0;

    // Reference model of the call in progress.
    phase_t      ph = P_IDLE;
    logic        last = 1'b1;
    logic        cur_id = 1'b0;
    logic [63:0] cur_s = '0;
    logic [31:0] cur_data = '0, exp_data = '0;
    logic        exp_err = 1'b0;
    bit          rsp_first = 1'b0;
    int cyc = 0, tcyc = 0, kwait = 0, lat = 0, accept_cyc = 0, flush_n = 0;
    int n_rsp = 0, n_err_rsp = 0, n_launch = 0, gnt_cyc = 0, rsp_cyc = 0;
    int gnt_log[$];

    task automatic model_step();
        logic g0, g1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (ph == P_IDLE) begin
            if (req0_valid && req1_valid) begin
                g0 = last;
                g1 = !last;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        check("sched_idle", sched_idle, ph == P_IDLE);
        check("k_start", k_start, ph == P_ISSUE);
        check("k_stall", k_stall, ph != P_RUN);
        check("k_reset", k_reset, ph == P_FLUSH);
        check("rsp_valid", rsp_valid, ph == P_RESP);
        case (ph)
            P_IDLE: begin
                if (g0 || g1) begin
                    cur_id  = g1;
                    cur_s   = g1 ? req1_s : req0_s;
                    gnt_log.push_back(int'(g1));
                    gnt_cyc = cyc;
                    tcyc    = 0;
                    ph      = P_ISSUE;
                end
            end
            P_ISSUE: begin
                check("k_s", k_s, cur_s);
                tcyc++;
                if (!k_busy) begin
                    ph         = P_RUN;
                    accept_cyc = cyc;
                    lat        = rnd ? int'($urandom_range(1, 6)) : lat_set;
                    kwait      = lat;
                    cur_data   = rnd ? $urandom : kdata_set;
                    n_launch++;
                end
            end
            P_RUN: begin
                if (k_done) begin
                    exp_data  = cur_data;
                    exp_err   = 1'b0;
                    rsp_first = 1'b1;
                    ph        = P_RESP;
                end
`ifdef EIA608_SCHED_TIMEOUT_EN
                else if (tcyc == TMO) begin
                    flush_n = 2;
                    ph      = P_FLUSH;
                end
`endif
                tcyc++;
            end
            P_FLUSH: begin
                flush_n--;
                if (flush_n == 0) begin
                    exp_data  = 32'hFFFF_FFFF;
                    exp_err   = 1'b1;
                    rsp_first = 1'b1;
                    ph        = P_RESP;
                end
            end
            P_RESP: begin
                check("rsp_data", rsp_data, exp_data);
                check("rsp_id", rsp_id, cur_id);
                check("rsp_err", rsp_err, exp_err);
                if (rsp_first) begin
                    rsp_cyc = cyc;
                    if (!exp_err) check("rsp_latency", cyc - accept_cyc, lat + 1);
                    else n_err_rsp++;
                end
                rsp_first = 1'b0;
                if (rsp_ready) begin
                    last = cur_id;
                    n_rsp++;
                    ph = P_IDLE;
                end
            end
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        cyc++;
        if (rnd) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            req0_s     = {$urandom, $urandom};
            req1_s     = {$urandom, $urandom};
            k_busy     = ($urandom_range(0, 99) < 30) && !(ph == P_ISSUE && tcyc >= 8);
            rsp_ready  = ($urandom_range(0, 99) < 50);
        end else begin
            req0_valid = d_req0_valid;
            req1_valid = d_req1_valid;
            req0_s     = d_req0_s;
            req1_s     = d_req1_s;
            k_busy     = d_busy;
            rsp_ready  = d_rsp_ready;
        end
        k_done       = 1'b0;
        k_returndata = $urandom;
        if (ph == P_RUN) begin
            kwait--;
            if (kwait == 0) begin
                k_done       = 1'b1;
                k_returndata = cur_data;
            end
        end else begin
            k_done = rnd ? ($urandom_range(0, 7) == 0) : d_spur;
        end
        @(negedge clock);
        model_step();
    endtask

    task automatic run_until(input phase_t target, input string tag);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (ph != target && n < 200);
        check(tag, ph == target, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        k_done = 1'b0;
        k_busy = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_k_start", k_start, 1'b0);
        check("rst_k_s", k_s, 64'h0);
        check("rst_k_stall", k_stall, 1'b1);
        check("rst_k_reset", k_reset, 1'b0);
        check("rst_sched_idle", sched_idle, 1'b1);
        reset = 1'b0;
        ph = P_IDLE;
        last = 1'b1;
        kwait = 0;
        rsp_first = 1'b0;
    endtask

    initial begin
        int base;
        do_reset();

        // Contention: both held valid for four calls.
        d_req0_s = 64'hAAAA_0000_0000_0001;
        d_req1_s = 64'hBBBB_0000_0000_0002;
        d_req0_valid = 1'b1;
        d_req1_valid = 1'b1;
        lat_set = 1;
        kdata_set = 32'hC0DE_0001;
        for (int i = 0; i < 100 && n_rsp < 4; i++) cycle();
        d_req0_valid = 1'b0;
        d_req1_valid = 1'b0;
        check("contention_grants", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++) check("contention_order", gnt_log[i], i % 2);

        // Single call from req0, kernel done two cycles after start.
        cycle();
        lat_set = 2;
        kdata_set = 32'h0000_0005;
        d_req0_s = 64'h1000;
        d_req0_valid = 1'b1;
        cycle();
        d_req0_valid = 1'b0;
        run_until(P_IDLE, "single_done");
        check("single_latency", rsp_cyc - gnt_cyc, 4);

        // Kernel busy for five cycles.
        base = n_launch;
        d_busy = 1'b1;
        d_req1_s = 64'h0123_4567_89AB_CDEF;
        d_req1_valid = 1'b1;
        lat_set = 3;
        kdata_set = 32'h1111_2222;
        cycle();
        d_req1_valid = 1'b0;
        repeat (5) cycle();
        d_busy = 1'b0;
        run_until(P_IDLE, "busy_done");
        check("busy_launches", n_launch - base, 1);

        // Consumer stalls for ten cycles while another request waits.
        d_rsp_ready = 1'b0;
        d_req0_s = 64'hDEAD_BEEF_0000_0010;
        d_req0_valid = 1'b1;
        kdata_set = 32'h3333_4444;
        run_until(P_RESP, "hold_reach_resp");
        repeat (10) cycle();
        d_req0_valid = 1'b0;
        d_rsp_ready = 1'b1;
        run_until(P_IDLE, "hold_done");

        // Spurious done in IDLE and RESP.
        base = n_rsp;
        d_spur = 1'b1;
        repeat (5) cycle();
        check("spur_idle_no_rsp", n_rsp - base, 0);
        d_rsp_ready = 1'b0;
        d_req1_s = 64'h5555;
        d_req1_valid = 1'b1;
        kdata_set = 32'h5A5A_0007;
        cycle();
        d_req1_valid = 1'b0;
        run_until(P_RESP, "spur_reach_resp");
        repeat (4) cycle();
        d_rsp_ready = 1'b1;
        run_until(P_IDLE, "spur_done");
        d_spur = 1'b0;
        check("spur_rsp_count", n_rsp - base, 1);

        // Randomized traffic.
        rnd = 1'b1;
        repeat (3000) cycle();
        rnd = 1'b0;
        d_busy = 1'b0;
        d_rsp_ready = 1'b1;
        run_until(P_IDLE, "random_drain");

        // Reset while the kernel is running, then a fresh req1 call.
        lat_set = 10;
        d_req0_s = 64'h7777;
        d_req0_valid = 1'b1;
        cycle();
        d_req0_valid = 1'b0;
        run_until(P_RUN, "rstwait_reach");
        cycle();
        cycle();
        do_reset();
        base = n_rsp;
        repeat (3) cycle();
        check("rstwait_dropped", n_rsp - base, 0);
        lat_set = 2;
        kdata_set = 32'h0000_1234;
        d_req1_s = 64'h8888;
        d_req1_valid = 1'b1;
        cycle();
        d_req1_valid = 1'b0;
        run_until(P_IDLE, "rstwait_next");
        check("rstwait_next_rsp", n_rsp - base, 1);

`ifdef EIA608_SCHED_TIMEOUT_EN
        // Hung kernel, then done arriving exactly in the timeout cycle.
        lat_set = 1000;
        d_req0_s = 64'h9999;
        d_req0_valid = 1'b1;
        cycle();
        d_req0_valid = 1'b0;
        run_until(P_IDLE, "tmo_done");
        check("tmo_err_rsp", n_err_rsp, 1);
        lat_set = TMO;
        kdata_set = 32'h0000_004D;
        d_req1_valid = 1'b1;
        cycle();
        d_req1_valid = 1'b0;
        run_until(P_IDLE, "tmo_race_done");
        check("tmo_race_err_rsp", n_err_rsp, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
